// File: rtl/openfire_lsu_pkg.sv
// Shared types and widths for the OpenFire load/store unit.
package openfire_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 8;

    // Access size encoding from EXECUTE; 2'b11 behaves as a word
    typedef enum logic [1:0] {
        DMEM_SIZE_BYTE = 2'b00,
        DMEM_SIZE_HALF = 2'b01,
        DMEM_SIZE_WORD = 2'b10
    } dmem_size_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_WAIT = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_e;

    // One outstanding bus transaction as presented on the external bus
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_xact_t;

endpackage

// File: rtl/openfire_lsu_if.sv
// External data-memory bus between the LSU (master) and memory (slave).
interface openfire_lsu_if;
    import openfire_lsu_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [BE_W-1:0]   bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/openfire_lsu_align.sv
// Big-endian lane steering: byte enables, replicated store data,
// zero-extended load extraction and misalignment detection.
module openfire_lsu_align
    import openfire_lsu_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_c_o,
    output logic [DATA_W-1:0] wdata_c_o,
    output logic [DATA_W-1:0] rdata_c_o,
    output logic              misalign_c_o
);

    // Lane 0 (addr 0) sits in bits 31:24, so the right-shift is (3-addr)*8
    always_comb begin
        be_c_o       = '0;
        wdata_c_o    = '0;
        rdata_c_o    = '0;
        misalign_c_o = 1'b0;
        case (size_i)
            DMEM_SIZE_BYTE: begin
                be_c_o    = 4'b1000 >> addr_lo_i;
                wdata_c_o = {4{wdata_i[7:0]}};
                rdata_c_o = DATA_W'(8'(rdata_i >> {~addr_lo_i, 3'b000}));
            end
            DMEM_SIZE_HALF: begin
                be_c_o       = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_c_o    = {2{wdata_i[15:0]}};
                rdata_c_o    = DATA_W'(16'(rdata_i >> {~addr_lo_i[1], 4'b0000}));
                misalign_c_o = addr_lo_i[0];
            end
            default: begin
                be_c_o       = 4'b1111;
                wdata_c_o    = wdata_i;
                rdata_c_o    = rdata_i;
                misalign_c_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/openfire_lsu.sv
// Load/store unit: one bus transaction per EXECUTE access, with timeout,
// misalignment trap and a held response until the pipeline consumes it.
module openfire_lsu
    import openfire_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              dmem_re,
    input  logic              dmem_we,
    input  logic [1:0]        dmem_size,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_data_out,
    output logic              dmem_done,
    output logic [DATA_W-1:0] dmem_data_in,
    output logic              dmem_align_exc,
    output logic              dmem_bus_err,
    openfire_lsu_if.master    bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    bus_xact_t         xact_q;
    logic              req_q;
    logic              done_q;
    logic [DATA_W-1:0] data_q;
    logic              align_q;
    logic              err_q;

    logic [1:0]        sel_addr_lo;
    logic [1:0]        sel_size;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] rdata_c;
    logic              misalign_c;

    // Steer from the live request in IDLE, from the latched access otherwise
    assign sel_addr_lo = (state_q == LSU_IDLE) ? dmem_addr[1:0] : addr_lo_q;
    assign sel_size    = (state_q == LSU_IDLE) ? dmem_size      : size_q;

    openfire_lsu_align u_align (
        .addr_lo_i    (sel_addr_lo),
        .size_i       (sel_size),
        .wdata_i      (dmem_data_out),
        .rdata_i      (bus.bus_rdata),
        .be_c_o       (be_c),
        .wdata_c_o    (wdata_c),
        .rdata_c_o    (rdata_c),
        .misalign_c_o (misalign_c)
    );

    // Access FSM with registered bus and response outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= LSU_IDLE;
            cnt_q     <= '0;
            addr_lo_q <= '0;
            size_q    <= '0;
            xact_q    <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            align_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (dmem_re || dmem_we) begin
                        addr_lo_q <= dmem_addr[1:0];
                        size_q    <= dmem_size;
                        if (misalign_c) begin
                            state_q <= LSU_RESP;
                            done_q  <= 1'b1;
                            align_q <= 1'b1;
                            err_q   <= 1'b0;
                            data_q  <= '0;
                        end else begin
                            state_q      <= LSU_WAIT;
                            req_q        <= 1'b1;
                            cnt_q        <= '0;
                            xact_q.we    <= dmem_we;
                            xact_q.addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
                            xact_q.be    <= be_c;
                            xact_q.wdata <= wdata_c;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (bus.bus_ack) begin
                        state_q <= LSU_RESP;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        align_q <= 1'b0;
                        err_q   <= 1'b0;
                        data_q  <= xact_q.we ? '0 : rdata_c;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= LSU_RESP;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        align_q <= 1'b0;
                        err_q   <= 1'b1;
                        data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LSU_RESP: begin
                    if (!stall) begin
                        state_q <= LSU_IDLE;
                        done_q  <= 1'b0;
                        align_q <= 1'b0;
                        err_q   <= 1'b0;
                        data_q  <= '0;
                    end
                end
                default: begin
                    state_q <= LSU_IDLE;
                    req_q   <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_done      = done_q;
    assign dmem_data_in   = data_q;
    assign dmem_align_exc = align_q;
    assign dmem_bus_err   = err_q;

    assign bus.bus_req    = req_q;
    assign bus.bus_we     = xact_q.we;
    assign bus.bus_addr   = xact_q.addr;
    assign bus.bus_be     = xact_q.be;
    assign bus.bus_wdata  = xact_q.wdata;

endmodule

// File: tb/tb_openfire_lsu.sv
// Directed bench for openfire_lsu; inputs driven and outputs sampled on negedge.
module tb_openfire_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        dmem_re;
    logic        dmem_we;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_data_out;
    logic        dmem_done;
    logic [31:0] dmem_data_in;
    logic        dmem_align_exc;
    logic        dmem_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    openfire_lsu_if bus_if ();

    openfire_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .dmem_re        (dmem_re),
        .dmem_we        (dmem_we),
        .dmem_size      (dmem_size),
        .dmem_addr      (dmem_addr),
        .dmem_data_out  (dmem_data_out),
        .dmem_done      (dmem_done),
        .dmem_data_in   (dmem_data_in),
        .dmem_align_exc (dmem_align_exc),
        .dmem_bus_err   (dmem_bus_err),
        .bus            (bus_if.master)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
        dmem_re       = re;
        dmem_we       = we;
        dmem_size     = size;
        dmem_addr     = addr;
        dmem_data_out = data;
    endtask

    task automatic idle_req();
        dmem_re = 1'b0;
        dmem_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int req_cycles;
        reset = 1'b0;
        stall = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clock);
        check_eq("rst_req",   32'(bus_if.bus_req), 32'h0);
        check_eq("rst_done",  32'(dmem_done), 32'h0);
        check_eq("rst_data",  dmem_data_in, 32'h0);
        check_eq("rst_flags", {30'h0, dmem_align_exc, dmem_bus_err}, 32'h0);
        check_eq("rst_be",    32'(bus_if.bus_be), 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // Byte store at 0x103, ack in the second WAIT cycle
        drive(1'b0, 1'b1, 2'b00, 32'h0000_0103, 32'h0000_00A5);
        @(negedge clock);
        idle_req();
        check_eq("bst_req",   32'(bus_if.bus_req), 32'h1);
        check_eq("bst_we",    32'(bus_if.bus_we), 32'h1);
        check_eq("bst_addr",  bus_if.bus_addr, 32'h0000_0100);
        check_eq("bst_be",    32'(bus_if.bus_be), 32'h1);
        check_eq("bst_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
        check_eq("bst_done0", 32'(dmem_done), 32'h0);
        @(negedge clock);
        check_eq("bst_req2",  32'(bus_if.bus_req), 32'h1);
        check_eq("bst_wdat2", bus_if.bus_wdata, 32'hA5A5_A5A5);
        bus_if.bus_ack = 1'b1;
        @(negedge clock);
        bus_if.bus_ack = 1'b0;
        check_eq("bst_done",  32'(dmem_done), 32'h1);
        check_eq("bst_reqlo", 32'(bus_if.bus_req), 32'h0);
        check_eq("bst_flags", {30'h0, dmem_align_exc, dmem_bus_err}, 32'h0);
        @(negedge clock);
        check_eq("bst_idle",  32'(dmem_done), 32'h0);

        // Half load at 0x202, zero-wait ack
        drive(1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0);
        @(negedge clock);
        idle_req();
        check_eq("hld_req",   32'(bus_if.bus_req), 32'h1);
        check_eq("hld_we",    32'(bus_if.bus_we), 32'h0);
        check_eq("hld_addr",  bus_if.bus_addr, 32'h0000_0200);
        check_eq("hld_be",    32'(bus_if.bus_be), 32'h3);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_ABCD;
        @(negedge clock);
        bus_if.bus_ack = 1'b0;
        check_eq("hld_done",  32'(dmem_done), 32'h1);
        check_eq("hld_data",  dmem_data_in, 32'h0000_ABCD);
        @(negedge clock);
        check_eq("hld_idle",  32'(dmem_done), 32'h0);

        // Misaligned word load at 0x301
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0301, 32'h0);
        @(negedge clock);
        idle_req();
        check_eq("mis_req",   32'(bus_if.bus_req), 32'h0);
        check_eq("mis_done",  32'(dmem_done), 32'h1);
        check_eq("mis_exc",   32'(dmem_align_exc), 32'h1);
        check_eq("mis_err",   32'(dmem_bus_err), 32'h0);
        @(negedge clock);
        check_eq("mis_idle",  32'(dmem_done), 32'h0);
        check_eq("mis_req2",  32'(bus_if.bus_req), 32'h0);

        // Timeout: ack never arrives, TIMEOUT_CYCLES = 4
        bus_if.bus_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0400, 32'h0);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            idle_req();
            if (dmem_done) break;
            if (bus_if.bus_req) req_cycles++;
        end
        check_eq("to_reqcyc", 32'(req_cycles), 32'd4);
        check_eq("to_done",   32'(dmem_done), 32'h1);
        check_eq("to_err",    32'(dmem_bus_err), 32'h1);
        check_eq("to_data",   dmem_data_in, 32'h0);
        check_eq("to_req",    32'(bus_if.bus_req), 32'h0);
        @(negedge clock);
        check_eq("to_idle",   32'(dmem_done), 32'h0);

        // Stall held in RESP for three cycles
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0);
        @(negedge clock);
        idle_req();
        stall            = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stl_done", 32'(dmem_done), 32'h1);
            check_eq("stl_data", dmem_data_in, 32'hDEAD_BEEF);
            check_eq("stl_req",  32'(bus_if.bus_req), 32'h0);
            @(negedge clock);
        end
        stall = 1'b0;
        check_eq("stl_cons",  32'(dmem_done), 32'h1);
        @(negedge clock);
        check_eq("stl_idle",  32'(dmem_done), 32'h0);
        check_eq("stl_noreq", 32'(bus_if.bus_req), 32'h0);

        // Reset asserted during WAIT, then a fresh byte load
        drive(1'b0, 1'b1, 2'b10, 32'h0000_0600, 32'h1122_3344);
        @(negedge clock);
        idle_req();
        check_eq("rw_req",    32'(bus_if.bus_req), 32'h1);
        check_eq("rw_wdata",  bus_if.bus_wdata, 32'h1122_3344);
        #2 reset = 1'b0;
        #1;
        check_eq("rw_reqlo",  32'(bus_if.bus_req), 32'h0);
        check_eq("rw_done",   32'(dmem_done), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rw_stay",   32'(bus_if.bus_req), 32'h0);
        drive(1'b1, 1'b0, 2'b00, 32'h0000_0601, 32'h0);
        @(negedge clock);
        idle_req();
        check_eq("rb_req",    32'(bus_if.bus_req), 32'h1);
        check_eq("rb_be",     32'(bus_if.bus_be), 32'h4);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hAABB_CCDD;
        @(negedge clock);
        bus_if.bus_ack = 1'b0;
        check_eq("rb_done",   32'(dmem_done), 32'h1);
        check_eq("rb_data",   dmem_data_in, 32'h0000_00BB);
        @(negedge clock);

        // re and we together: handled as a half store at 0x702
        drive(1'b1, 1'b1, 2'b01, 32'h0000_0702, 32'h0000_BEEF);
        @(negedge clock);
        idle_req();
        check_eq("rwb_we",    32'(bus_if.bus_we), 32'h1);
        check_eq("rwb_be",    32'(bus_if.bus_be), 32'h3);
        check_eq("rwb_wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
        bus_if.bus_ack = 1'b1;
        @(negedge clock);
        bus_if.bus_ack = 1'b0;
        check_eq("rwb_done",  32'(dmem_done), 32'h1);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
